sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STROBE_CYCLES, default 1, sets sram_write_enable/sram_read_enable high width in clk cycles (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_req  input  1  port A request, level; sampled only in IDLE.
REQ-005 a_we  input  1  port A op select: 1 = write, 0 = read; sampled with a_req.
REQ-006 a_addr  input  13  port A word address; sampled with a_req.
REQ-007 a_wdata  input  8  port A write data; sampled with a_req.
REQ-008 a_ack  output  1  port A one-cycle completion pulse.
REQ-009 a_rdata  output  8  port A read data; valid with a_ack on reads; held until next port A read completes.
REQ-010 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same directions/widths/meaning as port A, for port B.
REQ-011 sram_address  output  13  address to the SRAM.
REQ-012 sram_data  inout  8  SRAM bidirectional data bus.
REQ-013 sram_write_enable  output  1  SRAM write strobe; SRAM writes on its rising edge.
REQ-014 sram_read_enable  output  1  SRAM read strobe; SRAM drives sram_data while high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states shall be IDLE, SETUP, STROBE, RECOVER; all outputs registered.
REQ-017 IDLE: if any req high at clock edge, latch winner's we/addr/wdata, go SETUP; else stay IDLE.
REQ-018 Arbitration round-robin: single req wins; both high -> port named by priority pointer wins; pointer flips to the loser after each grant.
REQ-019 SETUP (1 cycle): sram_address = latched addr, both strobes low; on write, sram_data driven with latched wdata; on read, sram_data high-Z.
REQ-020 STROBE (STROBE_CYCLES cycles, counter): write -> sram_write_enable high, sram_data still driven; read -> sram_read_enable high, sram_data high-Z.
REQ-021 Read data captured from sram_data at the clock edge ending the last STROBE cycle into winner's rdata.
REQ-022 RECOVER (1 cycle): both strobes low, sram_data high-Z, address held; winner's ack high this cycle only; next state IDLE.
REQ-023 Latency: req seen at edge E -> ack high in cycle E+2+STROBE_CYCLES; back-to-back period = STROBE_CYCLES+3 cycles.
REQ-024 Req still high in IDLE after ack is a new request (requester must drop req on the ack edge to avoid a repeat).
REQ-025 sram_write_enable and sram_read_enable shall never be high in the same cycle.
REQ-026 Controller shall never drive sram_data in any cycle where sram_read_enable is high, nor in IDLE/RECOVER.
REQ-027 Inputs changing outside IDLE shall not affect the operation in flight.
REQ-028 a_ack and b_ack never high together; the non-winning port's rdata is unchanged.

Reset
REQ-029 rst high asynchronously forces: state IDLE, both strobes 0, sram_data high-Z, sram_address 0, a_ack/b_ack 0, a_rdata/b_rdata 0x00, busy 0, priority pointer = port A, strobe counter 0.
REQ-030 Reset mid-operation aborts it with no ack; first post-reset grant uses priority A.

Verification
REQ-031 a_req=1, a_we=1, a_addr=0x0123, a_wdata=0xA5 (STROBE_CYCLES=1) -> one write-strobe pulse, sram_data=0xA5 in SETUP+STROBE, a_ack 3 cycles after sampling edge.
REQ-032 Then a_we=0 read of 0x0123 -> sram_read_enable high one cycle, sram_data not driven by controller, a_rdata=0xA5 with a_ack.
REQ-033 a_req and b_req high together, held 4 accesses -> grants alternate A,B,A,B; acks never overlap.
REQ-034 Write 0x1FFF=0x3C and 0x0000=0xC3 then read both -> 0x3C and 0xC3 (address extremes, no aliasing).
REQ-035 rst pulsed during STROBE of a write -> strobes and bus drop immediately, no ack, busy 0; next b_req-only access completes normally.
REQ-036 STROBE_CYCLES=4, read -> sram_read_enable high exactly 4 cycles, ack at sampling edge+6; checker asserts no strobe overlap and no bus drive while read strobe high throughout.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous SRAM (8K x 8).
// Each access runs IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> RECOVER, and the
// winning port gets a one-cycle ack during RECOVER. All outputs are registered.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   {a,b}_req_i             request level, sampled only in IDLE
//   {a,b}_we_i              1 = write, 0 = read (sampled with req)
//   {a,b}_addr_i            13-bit word address (sampled with req)
//   {a,b}_wdata_i           write data (sampled with req)
//   {a,b}_ack_o             one-cycle completion pulse
//   {a,b}_rdata_o           read data, held until that port's next read completes
//   sram_address_o          SRAM address
//   sram_data_io            SRAM bidirectional data bus
//   sram_write_enable_o     SRAM write strobe (SRAM writes on its rising edge)
//   sram_read_enable_o      SRAM read strobe (SRAM drives the bus while high)
//   busy_o                  high in every state except IDLE
module sram_arbiter #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [12:0] a_addr_i,
  input  logic [7:0]  a_wdata_i,
  output logic        a_ack_o,
  output logic [7:0]  a_rdata_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [12:0] b_addr_i,
  input  logic [7:0]  b_wdata_i,
  output logic        b_ack_o,
  output logic [7:0]  b_rdata_o,
  output logic [12:0] sram_address_o,
  inout  wire  [7:0]  sram_data_io,
  output logic        sram_write_enable_o,
  output logic        sram_read_enable_o,
  output logic        busy_o
);

  localparam logic [3:0] LastCnt = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;      // 0: port A wins a tie, 1: port B
  logic        win_q, win_d;        // 0: port A owns the access in flight
  logic        we_lat_q, we_lat_d;
  logic [12:0] addr_lat_q, addr_lat_d;
  logic [7:0]  wdata_lat_q, wdata_lat_d;

  logic [12:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic        oe_q, oe_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        busy_q, busy_d;
  logic [7:0]  rdata_a_q, rdata_a_d;
  logic [7:0]  rdata_b_q, rdata_b_d;

  logic grant_b;
  assign grant_b = b_req_i & (~a_req_i | prio_q);

  // State register (includes the operands latched at grant time).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      win_q       <= 1'b0;
      we_lat_q    <= 1'b0;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      win_q       <= win_d;
      we_lat_q    <= we_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    win_d       = win_q;
    we_lat_d    = we_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    unique case (state_q)
      StIdle: begin
        if (a_req_i || b_req_i) begin
          win_d       = grant_b;
          prio_d      = ~grant_b;  // pointer moves to the port that did not win
          we_lat_d    = grant_b ? b_we_i    : a_we_i;
          addr_lat_d  = grant_b ? b_addr_i  : a_addr_i;
          wdata_lat_d = grant_b ? b_wdata_i : a_wdata_i;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic: decoded from the state being entered so every output is a flop.
  always_comb begin
    addr_d    = addr_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (state_d == StSetup) addr_d = addr_lat_d;
    wen_d   = (state_d == StStrobe) && we_lat_d;
    ren_d   = (state_d == StStrobe) && !we_lat_d;
    oe_d    = ((state_d == StSetup) || (state_d == StStrobe)) && we_lat_d;
    ack_a_d = (state_d == StRecover) && !win_d;
    ack_b_d = (state_d == StRecover) && win_d;
    busy_d  = (state_d != StIdle);
    // Capture on the edge that ends the last read strobe cycle.
    if ((state_q == StStrobe) && (state_d == StRecover) && !we_lat_q) begin
      if (win_q) rdata_b_d = sram_data_io;
      else       rdata_a_d = sram_data_io;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      oe_q      <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      oe_q      <= oe_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      busy_q    <= busy_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign sram_data_io        = oe_q ? wdata_lat_q : 8'hzz;
  assign sram_address_o      = addr_q;
  assign sram_write_enable_o = wen_q;
  assign sram_read_enable_o  = ren_q;
  assign a_ack_o             = ack_a_q;
  assign b_ack_o             = ack_b_q;
  assign a_rdata_o           = rdata_a_q;
  assign b_rdata_o           = rdata_b_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: STROBE_CYCLES=1 instance under directed and
// random traffic, plus a STROBE_CYCLES=4 instance for strobe width and latency.
// Each SRAM model drives the bus during its read strobe and otherwise holds it at
// 0x00 while the controller must be off the bus, so stray drive shows as a value.
module tb_sram_arbiter;
  localparam int unsigned S  = 1;
  localparam int unsigned S4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req, a_we, b_req, b_we, a_ack, b_ack, busy, s_we, s_re;
  logic [12:0] a_addr, b_addr, s_addr;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  wire  [7:0]  s_data;

  logic        d4_a_req, d4_a_we, d4_b_req, d4_b_we, d4_a_ack, d4_b_ack, d4_busy, d4_we, d4_re;
  logic [12:0] d4_a_addr, d4_b_addr, d4_addr;
  logic [7:0]  d4_a_wdata, d4_b_wdata, d4_a_rdata, d4_b_rdata;
  wire  [7:0]  d4_data;

  sram_arbiter #(.STROBE_CYCLES(S)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .sram_address_o(s_addr), .sram_data_io(s_data),
    .sram_write_enable_o(s_we), .sram_read_enable_o(s_re), .busy_o(busy)
  );

  sram_arbiter #(.STROBE_CYCLES(S4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(d4_a_req), .a_we_i(d4_a_we), .a_addr_i(d4_a_addr), .a_wdata_i(d4_a_wdata),
    .a_ack_o(d4_a_ack), .a_rdata_o(d4_a_rdata),
    .b_req_i(d4_b_req), .b_we_i(d4_b_we), .b_addr_i(d4_b_addr), .b_wdata_i(d4_b_wdata),
    .b_ack_o(d4_b_ack), .b_rdata_o(d4_b_rdata),
    .sram_address_o(d4_addr), .sram_data_io(d4_data),
    .sram_write_enable_o(d4_we), .sram_read_enable_o(d4_re), .busy_o(d4_busy)
  );

  // SRAM models.
  logic [7:0] mem  [8192];
  logic [7:0] mem4 [8192];
  assign s_data  = s_re  ? mem[s_addr]   : ((!busy || a_ack || b_ack) ? 8'h00 : 8'hzz);
  assign d4_data = d4_re ? mem4[d4_addr] : ((!d4_busy || d4_a_ack || d4_b_ack) ? 8'h00 : 8'hzz);

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    forever begin
      @(posedge s_we);
      mem[s_addr] = s_data;
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem4[i] = 8'h00;
    forever begin
      @(posedge d4_we);
      mem4[d4_addr] = d4_data;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference model: word memory, round-robin pointer, last read per port.
  typedef struct packed {
    logic        port;
    logic        wr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  model_mem [8192];
  logic        prio;
  logic [7:0]  exp_rd [2];
  int unsigned exp_wc, exp_rc;

  task automatic pick(input logic ar, input logic br, output logic w);
    w    = (ar && br) ? prio : br;
    prio = !w;
  endtask

  task automatic grant(input logic w, input int unsigned ack_cyc);
    exp_t        e;
    logic        we_;
    logic [12:0] ad;
    logic [7:0]  wd;
    we_ = w ? b_we    : a_we;
    ad  = w ? b_addr  : a_addr;
    wd  = w ? b_wdata : a_wdata;
    if (we_) begin
      model_mem[ad] = wd;
      exp_wc += S;
    end else begin
      exp_rc += S;
    end
    e.port = w;
    e.wr   = we_;
    e.wd   = wd;
    e.rd   = model_mem[ad];
    e.cyc  = ack_cyc;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every ack, checks bus rules every cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_overlap", 32'(s_we & s_re), 32'd0);
      chk("ack_overlap", 32'(a_ack & b_ack), 32'd0);
      if (!busy || a_ack || b_ack) chk("bus_free", 32'(s_data), 32'd0);
      if (a_ack || b_ack) begin
        if (q.size() == 0) begin
          fail("unexpected_ack");
        end else begin
          mon_e = q.pop_front();
          chk("ack_port", 32'(b_ack), 32'(mon_e.port));
          chk("ack_latency", cyc, mon_e.cyc);
          if (!mon_e.wr) exp_rd[mon_e.port] = mon_e.rd;
          chk("a_rdata", 32'(a_rdata), 32'(exp_rd[0]));
          chk("b_rdata", 32'(b_rdata), 32'(exp_rd[1]));
        end
      end
      chk("d4_strobe_overlap", 32'(d4_we & d4_re), 32'd0);
      chk("d4_b_ack", 32'(d4_b_ack), 32'd0);
      if (!d4_busy || d4_a_ack) chk("d4_bus_free", 32'(d4_data), 32'd0);
    end
  end

  task automatic set_a(input logic we, input logic [12:0] ad, input logic [7:0] wd);
    a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic we, input logic [12:0] ad, input logic [7:0] wd);
    b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (!busy && !d4_busy) return;
    end
    fail(name);
  endtask

  // Raise the requests for n grants, then drop them during the last RECOVER.
  // Called at a falling edge with the controller idle.
  task automatic run_txn(input logic ar, input logic br, input int n);
    logic        w;
    int unsigned e0;
    int          acks, wc, rc;
    e0 = cyc + 1;
    exp_wc = 0;
    exp_rc = 0;
    for (int k = 0; k < n; k++) begin
      pick(ar, br, w);
      // ack is the cycle ending at edge E+S+2, seen here after edge E+S+1
      grant(w, e0 + int'(k) * (S + 3) + S + 1);
    end
    a_req = ar;
    b_req = br;
    acks = 0; wc = 0; rc = 0;
    for (int t = 0; t < n * (S + 3) + 8 && acks < n; t++) begin
      @(negedge clk);
      if (s_we) begin
        wc++;
        if (q.size() > 0) chk("write_bus", 32'(s_data), 32'(q[0].wd));
      end
      if (s_re) rc++;
      if (a_ack || b_ack) begin
        acks++;
        if (acks == n) begin
          a_req = 1'b0;
          b_req = 1'b0;
        end
      end
    end
    if (acks < n) fail("ack_timeout");
    a_req = 1'b0;
    b_req = 1'b0;
    chk("we_cycles", 32'(wc), exp_wc);
    chk("re_cycles", 32'(rc), exp_rc);
    wait_idle("idle_timeout");
  endtask

  task automatic reset_state_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"}, 32'(s_we), 32'd0);
    chk({tag, "_re"}, 32'(s_re), 32'd0);
    chk({tag, "_addr"}, 32'(s_addr), 32'd0);
    chk({tag, "_acks"}, 32'({a_ack, b_ack}), 32'd0);
    chk({tag, "_a_rdata"}, 32'(a_rdata), 32'd0);
    chk({tag, "_b_rdata"}, 32'(b_rdata), 32'd0);
    chk({tag, "_bus"}, 32'(s_data), 32'd0);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 reset_state_check(tag);
    q.delete();
    prio = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic d4_txn(input logic we, input logic [12:0] ad, input logic [7:0] wd,
                        input logic [7:0] exp_v);
    int unsigned e0, ack_cyc;
    int          sc;
    logic        got;
    d4_a_we = we; d4_a_addr = ad; d4_a_wdata = wd;
    e0 = cyc + 1;
    d4_a_req = 1'b1;
    sc = 0; got = 1'b0; ack_cyc = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (we ? d4_we : d4_re) sc++;
      if (d4_a_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
        d4_a_req = 1'b0;
      end
    end
    d4_a_req = 1'b0;
    if (!got) fail("d4_ack_timeout");
    chk("d4_strobe_cycles", 32'(sc), S4);
    chk("d4_ack_latency", ack_cyc, e0 + S4 + 1);
    if (!we) chk("d4_rdata", 32'(d4_a_rdata), 32'(exp_v));
    wait_idle("d4_idle_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic        w;
    logic [1:0]  r;
    logic [7:0]  d;
    rst = 1'b1;
    a_req = 0; b_req = 0; set_a(0, 0, 0); set_b(0, 0, 0);
    d4_a_req = 0; d4_a_we = 0; d4_a_addr = 0; d4_a_wdata = 0;
    d4_b_req = 0; d4_b_we = 0; d4_b_addr = 0; d4_b_wdata = 0;
    for (int i = 0; i < 8192; i++) model_mem[i] = 8'h00;
    prio = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    reset_state_check("por");
    chk("por_d4_busy", 32'(d4_busy), 32'd0);
    chk("por_d4_rdata", 32'(d4_a_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back 0x0123.
    set_a(1, 13'h0123, 8'hA5); run_txn(1, 0, 1);
    set_a(0, 13'h0123, 8'h5A); run_txn(1, 0, 1);

    // Address extremes.
    set_a(1, 13'h1FFF, 8'h3C); run_txn(1, 0, 1);
    set_b(1, 13'h0000, 8'hC3); run_txn(0, 1, 1);
    set_a(0, 13'h1FFF, 8'hFF); run_txn(1, 0, 1);
    set_b(0, 13'h0000, 8'hFF); run_txn(0, 1, 1);

    // Both held for four accesses: alternating grants.
    set_a(1, 13'h0005, 8'h11); set_b(1, 13'h0006, 8'h22); run_txn(1, 1, 4);
    set_a(0, 13'h0006, 8'h00); set_b(0, 13'h0005, 8'h00); run_txn(1, 1, 4);

    // Reset during the write strobe: no ack, bus released at once.
    set_a(1, 13'h0777, 8'h96);
    pick(1, 0, w);
    model_mem[13'h0777] = 8'h96;  // the strobe rising edge is seen before the reset
    a_req = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      if (s_we) seen = 1'b1;
    end
    chk("abort_strobe_seen", 32'(seen), 32'd1);
    do_reset("abort");
    set_b(0, 13'h0777, 8'h00); run_txn(0, 1, 1);

    // Pointer returns to A after reset even when it was pointing at B.
    set_a(1, 13'h0010, 8'h4B); run_txn(1, 0, 1);
    @(negedge clk);
    do_reset("rst2");
    set_a(0, 13'h0010, 8'h00); set_b(0, 13'h0777, 8'h00); run_txn(1, 1, 1);

    // Random traffic.
    for (int it = 0; it < 80; it++) begin
      r = 2'($urandom_range(1, 3));
      set_a(1'($urandom), ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7)),
            8'($urandom));
      set_b(1'($urandom), ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 7)),
            8'($urandom));
      run_txn(r[0], r[1], ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 4)) : 1);
    end

    // Four-cycle strobe instance.
    d4_txn(1, 13'h0ABC, 8'h5A, 8'h00);
    d4_txn(0, 13'h0ABC, 8'hA5, 8'h5A);
    d = 8'($urandom_range(1, 255));
    d4_txn(1, 13'h1FFF, d, 8'h00);
    d4_txn(0, 13'h1FFF, ~d, d);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
